warp_dispatch: RTL and testbench

//  Upstream block dispatcher for one dual-warp compute core. Splits a kernel's thread count into

---
 rtl/warp_dispatch_if.sv | 37 +++
 rtl/warp_dispatch.sv | 122 ++++++++++++
 tb/tb_warp_dispatch.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/warp_dispatch_if.sv
// Bundle between the warp dispatcher and its surroundings: kernel control on one side,
// the two warp-slot control/status pairs on the other.
interface warp_dispatch_if #(
    parameter int THREADS_PER_BLOCK = 4
);
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

    // All signals are levels. start is held high while the kernel should run and is only
    // looked at in the idle kernel state. done_x is taken as a completion only in the cycle
    // the slot is in RUN; start_x drops combinationally in that cycle. done stays until reset.
    logic           start;
    logic [7:0]     thread_count;
    logic           done;
    logic           reset_1;
    logic           reset_2;
    logic           start_1;
    logic           start_2;
    logic [7:0]     block_id_1;
    logic [7:0]     block_id_2;
    logic [TCW-1:0] thread_count_1;
    logic [TCW-1:0] thread_count_2;
    logic           done_1;
    logic           done_2;
    logic [5:0]     dbg_state;

    modport master (
        input  start, thread_count, done_1, done_2,
        output done, reset_1, reset_2, start_1, start_2,
        output block_id_1, block_id_2, thread_count_1, thread_count_2, dbg_state
    );

    modport slave (
        output start, thread_count, done_1, done_2,
        input  done, reset_1, reset_2, start_1, start_2,
        input  block_id_1, block_id_2, thread_count_1, thread_count_2, dbg_state
    );
endinterface

// File: rtl/warp_dispatch.sv
// Splits a kernel into fixed-size thread blocks and hands them to two warp slots,
// raising done once every issued block has reported completion.
module warp_dispatch #(
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic            clk,
    input  logic            reset,
    warp_dispatch_if.master bus
);
    localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;
    localparam int LOG = $clog2(THREADS_PER_BLOCK);
    localparam logic [7:0] MASK = 8'(THREADS_PER_BLOCK - 1);

    typedef enum logic [1:0] {K_IDLE, K_RUN, K_DONE} kstate_t;
    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN} sstate_t;

    kstate_t        kstate, k_nxt;
    sstate_t        s1, s2, s1_nxt, s2_nxt;
    logic [7:0]     n_q, total_q, next_block, blocks_done;
    logic [7:0]     id1_q, id2_q;
    logic [TCW-1:0] tc1_q, tc2_q;
    logic           rst_q;

    logic           launch, claim1, claim2, fin1, fin2;
    logic [7:0]     remaining, id2_new, total_calc;

    // Size of block id within a kernel of n threads: full unless it is the tail block.
    function automatic logic [TCW-1:0] block_size(input logic [7:0] n, input logic [7:0] id);
        logic [15:0] rem;
        rem = {8'd0, n} - ({8'd0, id} << LOG);
        if (rem >= 16'(THREADS_PER_BLOCK)) block_size = TCW'(THREADS_PER_BLOCK);
        else                               block_size = rem[TCW-1:0];
    endfunction

    assign total_calc = (bus.thread_count >> LOG) + {7'd0, |(bus.thread_count & MASK)};
    assign remaining  = total_q - next_block;
    assign launch     = (kstate == K_IDLE) && bus.start;
    assign claim1     = (kstate == K_RUN) && (s1 == S_IDLE) && (remaining != 8'd0);
    assign claim2     = (kstate == K_RUN) && (s2 == S_IDLE) &&
                        (claim1 ? (remaining >= 8'd2) : (remaining != 8'd0));
    assign id2_new    = claim1 ? next_block + 8'd1 : next_block;
    assign fin1       = (s1 == S_RUN) && bus.done_1;
    assign fin2       = (s2 == S_RUN) && bus.done_2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            kstate <= K_IDLE;
            s1     <= S_IDLE;
            s2     <= S_IDLE;
        end else begin
            kstate <= k_nxt;
            s1     <= s1_nxt;
            s2     <= s2_nxt;
        end
    end

    always_comb begin
        k_nxt  = kstate;
        s1_nxt = s1;
        s2_nxt = s2;
        case (kstate)
            K_IDLE:  if (bus.start) k_nxt = (bus.thread_count == 8'd0) ? K_DONE : K_RUN;
            K_RUN:   if (blocks_done == total_q) k_nxt = K_DONE;
            default: k_nxt = K_DONE;
        endcase
        case (s1)
            S_IDLE:  if (claim1) s1_nxt = S_RST;
            S_RST:   s1_nxt = S_RUN;
            default: if (bus.done_1) s1_nxt = S_IDLE;
        endcase
        case (s2)
            S_IDLE:  if (claim2) s2_nxt = S_RST;
            S_RST:   s2_nxt = S_RUN;
            default: if (bus.done_2) s2_nxt = S_IDLE;
        endcase
    end

    // rst_q keeps both slot resets asserted for every cycle the dispatcher is held in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            n_q         <= 8'd0;
            total_q     <= 8'd0;
            next_block  <= 8'd0;
            blocks_done <= 8'd0;
            id1_q       <= 8'd0;
            id2_q       <= 8'd0;
            tc1_q       <= '0;
            tc2_q       <= '0;
            rst_q       <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (launch) begin
                n_q         <= bus.thread_count;
                total_q     <= total_calc;
                next_block  <= 8'd0;
                blocks_done <= 8'd0;
            end else begin
                next_block  <= next_block + {7'd0, claim1} + {7'd0, claim2};
                blocks_done <= blocks_done + {7'd0, fin1} + {7'd0, fin2};
            end
            if (claim1) begin
                id1_q <= next_block;
                tc1_q <= block_size(n_q, next_block);
            end
            if (claim2) begin
                id2_q <= id2_new;
                tc2_q <= block_size(n_q, id2_new);
            end
        end
    end

    assign bus.done           = (kstate == K_DONE);
    assign bus.reset_1        = rst_q || (s1 == S_RST);
    assign bus.reset_2        = rst_q || (s2 == S_RST);
    assign bus.start_1        = (s1 == S_RUN) && !bus.done_1;
    assign bus.start_2        = (s2 == S_RUN) && !bus.done_2;
    assign bus.block_id_1     = id1_q;
    assign bus.block_id_2     = id2_q;
    assign bus.thread_count_1 = tc1_q;
    assign bus.thread_count_2 = tc2_q;
    assign bus.dbg_state      = {kstate, s1, s2};
endmodule

// File: tb/tb_warp_dispatch.sv
// Bench for warp_dispatch: a TPB=4 instance checked every cycle against a block-queue model,
// and a TPB=1 instance driven through a full 255-block kernel.
module tb_warp_dispatch;
    localparam int TPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, reset_b;
    warp_dispatch_if #(.THREADS_PER_BLOCK(4)) ifa ();
    warp_dispatch_if #(.THREADS_PER_BLOCK(1)) ifb ();

    warp_dispatch #(.THREADS_PER_BLOCK(4)) dut_a (.clk(clk), .reset(reset),   .bus(ifa.master));
    warp_dispatch #(.THREADS_PER_BLOCK(1)) dut_b (.clk(clk), .reset(reset_b), .bus(ifb.master));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model for dut_a: pending block ids, per-slot phase (0 free, 1 reset pulse,
    // 2 running), kernel phase (0 waiting, 1 running, 2 finished), completions counted.
    logic [7:0] exp_q[$];
    int         ph[2];
    int         lat[2];
    int         mid[2];
    int         mtc[2];
    int         kph, m_n, m_total, comp;
    logic       d_drv[2];
    bit         hold[2];
    bit         sync_mode;
    bit         claimed_now[2];

    int         comp_b, nb;
    logic       db[2];

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic       rs_p, st_p, rsb_p;
        logic [7:0] tc_in;
        logic       dp[2];
        logic       dbp[2];
        int         ph_prev[2];
        int         comp_prev;
        bit         rdy[2];
        rs_p  = reset;
        st_p  = ifa.start;
        tc_in = ifa.thread_count;
        dp    = d_drv;
        rsb_p = reset_b;
        dbp   = db;
        @(posedge clk);
        #1;
        claimed_now = '{0, 0};
        if (!rs_p) begin
            ph  = '{0, 0};
            mid = '{0, 0};
            mtc = '{0, 0};
            kph = 0;
            comp = 0;
            exp_q.delete();
        end else begin
            ph_prev   = ph;
            comp_prev = comp;
            for (int i = 0; i < 2; i++) begin
                if (ph_prev[i] == 2 && dp[i]) begin
                    comp++;
                    ph[i] = 0;
                end else if (ph_prev[i] == 1) begin
                    ph[i]  = 2;
                    lat[i] = $urandom_range(0, 3);
                end
            end
            if (kph == 1) begin
                if (comp_prev == m_total) kph = 2;
                for (int i = 0; i < 2; i++) begin
                    if (ph_prev[i] == 0 && exp_q.size() > 0) begin
                        mid[i] = int'(exp_q.pop_front());
                        mtc[i] = min_i(TPB, m_n - mid[i] * TPB);
                        ph[i]  = 1;
                        claimed_now[i] = 1'b1;
                    end
                end
            end else if (kph == 0 && st_p) begin
                m_n     = int'(tc_in);
                m_total = (m_n + TPB - 1) / TPB;
                exp_q.delete();
                for (int id = 0; id < m_total; id++) exp_q.push_back(8'(id));
                comp = 0;
                kph  = (m_n == 0) ? 2 : 1;
            end
        end
        chk("reset_1",        ifa.reset_1,        32'(!rs_p || ph[0] == 1));
        chk("reset_2",        ifa.reset_2,        32'(!rs_p || ph[1] == 1));
        chk("start_1",        ifa.start_1,        32'(ph[0] == 2 && !dp[0]));
        chk("start_2",        ifa.start_2,        32'(ph[1] == 2 && !dp[1]));
        chk("done",           ifa.done,           32'(kph == 2));
        chk("block_id_1",     ifa.block_id_1,     32'(mid[0]));
        chk("block_id_2",     ifa.block_id_2,     32'(mid[1]));
        chk("thread_count_1", ifa.thread_count_1, 32'(mtc[0]));
        chk("thread_count_2", ifa.thread_count_2, 32'(mtc[1]));
        // Slot responder: finish after a random latency, optionally in lock-step.
        for (int i = 0; i < 2; i++) begin
            rdy[i] = (ph[i] == 2) && !hold[i] && (lat[i] == 0);
            if (ph[i] == 2 && !hold[i] && lat[i] > 0) lat[i]--;
        end
        for (int i = 0; i < 2; i++)
            d_drv[i] = rdy[i] && (!sync_mode || rdy[1-i] || ph[1-i] != 2);
        ifa.done_1 = d_drv[0];
        ifa.done_2 = d_drv[1];

        if (rsb_p) begin
            for (int i = 0; i < 2; i++) if (dbp[i]) comp_b++;
            if (ifb.reset_1) begin
                chk("b_block_id_1", ifb.block_id_1, 32'(nb));
                chk("b_tc_1", ifb.thread_count_1, 32'd1);
                nb++;
            end
            if (ifb.reset_2) begin
                chk("b_block_id_2", ifb.block_id_2, 32'(nb));
                chk("b_tc_2", ifb.thread_count_2, 32'd1);
                nb++;
            end
            if (ifb.done === 1'b1) chk("b_done_early", comp_b, 32'd255);
            db[0] = ifb.start_1;
            db[1] = ifb.start_2;
        end else begin
            db = '{1'b0, 1'b0};
        end
        ifb.done_1 = db[0];
        ifb.done_2 = db[1];
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ifa.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic launch(input int n);
        ifa.thread_count = 8'(n);
        ifa.start = 1'b1;
        tick();
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (ifa.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("done_reached", ifa.done, 32'd1);
    endtask

    task automatic wait_claim(input int slot, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!claimed_now[slot] && n < 100);
        chk(tag, 32'(claimed_now[slot]), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        reset_b = 1'b0;
        ifa.start = 1'b0;
        ifa.thread_count = 8'd0;
        ifa.done_1 = 1'b0;
        ifa.done_2 = 1'b0;
        ifb.start = 1'b0;
        ifb.thread_count = 8'd0;
        ifb.done_1 = 1'b0;
        ifb.done_2 = 1'b0;
        d_drv = '{1'b0, 1'b0};
        db = '{1'b0, 1'b0};
        hold = '{0, 0};
        lat = '{0, 0};
        sync_mode = 1'b0;
        comp_b = 0;
        nb = 0;
        tick();
        tick();
        chk("b_reset_1_in_reset", ifb.reset_1, 32'd1);
        chk("b_start_1_in_reset", ifb.start_1, 32'd0);
        chk("b_done_in_reset",    ifb.done,    32'd0);
        reset = 1'b1;

        // Two full blocks claimed together by both slots.
        launch(8);
        tick();
        chk("t1_both_claim", {ifa.reset_1, ifa.reset_2}, 32'b11);
        chk("t1_id1", ifa.block_id_1, 32'd0);
        chk("t1_id2", ifa.block_id_2, 32'd1);
        chk("t1_tc1", ifa.thread_count_1, 32'd4);
        chk("t1_tc2", ifa.thread_count_2, 32'd4);
        tick();
        chk("t1_start_both", {ifa.start_1, ifa.start_2}, 32'b11);
        run_until_done(100);
        for (int i = 0; i < 3; i++) tick();
        chk("t1_done_held", ifa.done, 32'd1);
        do_reset();

        // Tail block of two threads goes to slot 2 while slot 1 is stalled.
        hold[0] = 1'b1;
        launch(10);
        tick();
        wait_claim(1, "t2_reclaim");
        chk("t2_id2", ifa.block_id_2, 32'd2);
        chk("t2_tc2", ifa.thread_count_2, 32'd2);
        chk("t2_rst_pulse", {ifa.reset_2, ifa.start_2}, 32'b10);
        tick();
        chk("t2_run", {ifa.reset_2, ifa.start_2}, 32'b01);
        hold[0] = 1'b0;
        run_until_done(100);
        do_reset();

        // Empty kernel.
        launch(0);
        chk("t3_done_fast", ifa.done, 32'd1);
        tick();
        chk("t3_quiet", {ifa.start_1, ifa.start_2, ifa.reset_1, ifa.reset_2}, 32'd0);
        do_reset();

        // Simultaneous completions free both slots at once.
        sync_mode = 1'b1;
        launch(16);
        tick();
        wait_claim(0, "t4_reclaim");
        chk("t4_both_claim", {ifa.reset_1, ifa.reset_2}, 32'b11);
        chk("t4_id1", ifa.block_id_1, 32'd2);
        chk("t4_id2", ifa.block_id_2, 32'd3);
        run_until_done(100);
        sync_mode = 1'b0;
        do_reset();

        // Reset mid-run aborts, then start still high relaunches from block 0.
        launch(12);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        tick();
        chk("t5_abort", {ifa.reset_1, ifa.reset_2, ifa.start_1, ifa.start_2, ifa.done}, 32'b11000);
        reset = 1'b1;
        tick();
        tick();
        chk("t5_restart_id1", ifa.block_id_1, 32'd0);
        chk("t5_restart_id2", ifa.block_id_2, 32'd1);
        run_until_done(100);
        do_reset();

        // Random kernels with random completion latency and pairing.
        for (int r = 0; r < 8; r++) begin
            sync_mode = 1'($urandom_range(0, 1));
            launch($urandom_range(0, 255));
            ifa.start = 1'($urandom_range(0, 1));
            run_until_done(1500);
            sync_mode = 1'b0;
            do_reset();
        end

        // 255 single-thread blocks on the TPB=1 instance.
        reset_b = 1'b1;
        ifb.thread_count = 8'd255;
        ifb.start = 1'b1;
        begin
            int n = 0;
            while (ifb.done !== 1'b1 && n < 3000) begin
                tick();
                n++;
            end
        end
        tick();
        tick();
        chk("b_done", ifb.done, 32'd1);
        chk("b_claims", nb, 32'd255);
        chk("b_completions", comp_b, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
